// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine feeding the HI/LO pair.
// Radix-2 shift-add multiply and restoring divide on magnitudes, with a final sign-fix cycle.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Kill,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  state_t             state;
  logic               is_div, sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;   // multiply: {partial, multiplier}; divide: low half is the quotient shifter
  logic [WIDTH:0]     rem;

  logic               start_sa, start_sb;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, raw_a;

  always_comb begin
    start_sa  = ~Op[0] & A[WIDTH-1];
    start_sb  = ~Op[0] & B[WIDTH-1];
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_b};
    div_ge    = (div_shift >= {1'b0, mag_b});
    prod_fix  = (sa ^ sb) ? -acc : acc;
    quo_fix   = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = sa ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    raw_a     = sa ? -mag_a : mag_a;   // undo the magnitude for the divide-by-zero passthrough
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      HiOut     <= '0;
      LoOut     <= '0;
      DivByZero <= 1'b0;
      is_div    <= 1'b0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      mag_a     <= '0;
      mag_b     <= '0;
      cnt       <= '0;
      acc       <= '0;
      rem       <= '0;
    end else if (Kill) begin
      state <= IDLE;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          Done <= 1'b0;
          if (Start) begin
            state     <= PREP;
            Busy      <= 1'b1;
            DivByZero <= 1'b0;
            is_div    <= Op[1];
            sa        <= start_sa;
            sb        <= start_sb;
            mag_a     <= start_sa ? -A : A;
            mag_b     <= start_sb ? -B : B;
          end else begin
            state <= IDLE;
          end
        end
        PREP: begin
          cnt <= CW'(WIDTH);
          rem <= '0;
          if (is_div && mag_b == '0) begin
            state     <= DONE;
            Busy      <= 1'b0;
            Done      <= 1'b1;
            HiOut     <= raw_a;
            LoOut     <= '1;
            DivByZero <= 1'b1;
          end else begin
            state <= RUN;
            acc   <= {{WIDTH{1'b0}}, is_div ? mag_a : mag_b};
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (is_div) begin
            rem            <= div_ge ? div_diff : div_shift;
            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_ge};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          state <= DONE;
          Busy  <= 1'b0;
          Done  <= 1'b1;
          if (is_div) begin
            HiOut <= rem_fix;
            LoOut <= quo_fix;
          end else begin
            {HiOut, LoOut} <= prod_fix;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench: arithmetic/latency model checked every cycle, plus directed literal results.
module tb_hilo_muldiv_unit;
  localparam int W = 32;

  logic         Clk = 1'b0, Rst = 1'b1, Start = 1'b0, Kill = 1'b0;
  logic [1:0]   Op = '0;
  logic [W-1:0] A = '0, B = '0;
  logic         Busy, Done, DivByZero;
  logic [W-1:0] HiOut, LoOut;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B), .Kill(Kill),
    .Busy(Busy), .Done(Done), .HiOut(HiOut), .LoOut(LoOut), .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;

  int checks = 0, failures = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // {dbz, hi, lo} from plain arithmetic
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p, qq, rr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: begin p = sa * sb; return {1'b0, p}; end
      2'd1: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
      2'd2: begin
        if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
        q = sa / sb; r = sa % sb; qq = q; rr = r;
        return {1'b0, rr[31:0], qq[31:0]};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
        q = {32'b0, a} / {32'b0, b}; r = {32'b0, a} % {32'b0, b}; qq = q; rr = r;
        return {1'b0, rr[31:0], qq[31:0]};
      end
    endcase
  endfunction

  logic         m_busy, m_done, m_dbz;
  logic [W-1:0] m_hi, m_lo;
  logic [64:0]  pend_res;
  int           pend;

  // Timing model: result lands WIDTH+2 edges after acceptance (1 edge for divide by zero)
  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_busy = 0; m_done = 0; m_dbz = 0; m_hi = '0; m_lo = '0; pend = 0;
    end else if (Kill) begin
      m_busy = 0; m_done = 0; pend = 0;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        m_busy = 0; m_done = 1;
        {m_dbz, m_hi, m_lo} = pend_res;
      end
    end else begin
      m_done = 0;
      if (Start) begin
        pend_res = model(Op, A, B);
        pend     = (Op[1] && B == 0) ? 1 : W + 2;
        m_busy   = 1;
        m_dbz    = 0;
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("busy", 64'(Busy), 64'(m_busy));
      chk("done", 64'(Done), 64'(m_done));
      chk("hi",   64'(HiOut), 64'(m_hi));
      chk("lo",   64'(LoOut), 64'(m_lo));
      chk("dbz",  64'(DivByZero), 64'(m_dbz));
    end
  end

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Op = op; A = a; B = b; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Returns the cycle number (cycle 1 = first cycle after the Start edge) in which Done is seen
  task automatic wait_done(output int n);
    n = 1;
    while (!Done && n < 100) begin
      @(negedge Clk);
      n++;
    end
  endtask

  logic [1:0]  t_op[6] = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd2, 2'd1};
  logic [31:0] t_a[6]  = '{32'h80000000, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF8, 32'h00010000};
  logic [31:0] t_b[6]  = '{32'h80000000, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFF, 32'd0, 32'h00010000};
  logic [31:0] t_h[6]  = '{32'h40000000, 32'd1, 32'd0, 32'd0, 32'hFFFFFFF8, 32'd1};
  logic [31:0] t_l[6]  = '{32'd0, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0};
  logic        t_z[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int n;
    #1 Rst = 1'b0;
    chk_en = 1;
    repeat (2) @(negedge Clk);
    chk("rst_busy", 64'(Busy), 64'h0);
    chk("rst_done", 64'(Done), 64'h0);
    chk("rst_hi",   64'(HiOut), 64'h0);
    chk("rst_lo",   64'(LoOut), 64'h0);
    chk("rst_dbz",  64'(DivByZero), 64'h0);
    Rst = 1'b1;
    @(negedge Clk);

    launch(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(n);
    chk("multu_lat", 64'(n), 64'd35);
    chk("multu_hi", 64'(HiOut), 64'hFFFFFFFE);
    chk("multu_lo", 64'(LoOut), 64'h1);

    @(negedge Clk);
    launch(2'd0, 32'hFFFFFFFD, 32'd7);
    wait_done(n);
    chk("mult_hi", 64'(HiOut), 64'hFFFFFFFF);
    chk("mult_lo", 64'(LoOut), 64'hFFFFFFEB);
    launch(2'd2, 32'hFFFFFFF9, 32'd2);   // started in the DONE cycle
    wait_done(n);
    chk("b2b_lat", 64'(n), 64'd35);
    chk("div_lo", 64'(LoOut), 64'hFFFFFFFD);
    chk("div_hi", 64'(HiOut), 64'hFFFFFFFF);

    @(negedge Clk);
    launch(2'd3, 32'h12345678, 32'd0);
    wait_done(n);
    chk("dbz_lat", 64'(n), 64'd2);
    chk("dbz_flag", 64'(DivByZero), 64'h1);
    chk("dbz_hi", 64'(HiOut), 64'h12345678);
    chk("dbz_lo", 64'(LoOut), 64'hFFFFFFFF);
    launch(2'd3, 32'd100, 32'd7);
    chk("dbz_clear", 64'(DivByZero), 64'h0);
    wait_done(n);
    chk("divu_lo", 64'(LoOut), 64'd14);
    chk("divu_hi", 64'(HiOut), 64'd2);

    @(negedge Clk);
    launch(2'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n);
    chk("ovf_lo", 64'(LoOut), 64'h80000000);
    chk("ovf_hi", 64'(HiOut), 64'h0);
    chk("ovf_dbz", 64'(DivByZero), 64'h0);

    // Kill mid-RUN, with an ignored Start pulse before it
    @(negedge Clk);
    launch(2'd1, 32'd5, 32'd6);
    repeat (3) @(negedge Clk);
    Op = 2'd0; A = 32'd9; B = 32'd9; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (5) @(negedge Clk);
    Kill = 1'b1;
    @(negedge Clk);
    Kill = 1'b0;
    chk("kill_busy", 64'(Busy), 64'h0);
    chk("kill_hi", 64'(HiOut), 64'h0);
    chk("kill_lo", 64'(LoOut), 64'h80000000);
    launch(2'd1, 32'd5, 32'd6);
    wait_done(n);
    chk("after_kill_lat", 64'(n), 64'd35);
    chk("after_kill_lo", 64'(LoOut), 64'd30);

    @(negedge Clk);
    Kill = 1'b1; Start = 1'b1; Op = 2'd1; A = 32'd1; B = 32'd1;
    @(negedge Clk);
    Kill = 1'b0; Start = 1'b0;
    chk("kill_over_start", 64'(Busy), 64'h0);

    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      launch(t_op[i], t_a[i], t_b[i]);
      wait_done(n);
      chk($sformatf("vec%0d_done", i), 64'(Done), 64'h1);
      chk($sformatf("vec%0d_hi", i), 64'(HiOut), 64'(t_h[i]));
      chk($sformatf("vec%0d_lo", i), 64'(LoOut), 64'(t_l[i]));
      chk($sformatf("vec%0d_dbz", i), 64'(DivByZero), 64'(t_z[i]));
    end

    // Asynchronous reset between clock edges, mid-RUN
    @(negedge Clk);
    launch(2'd1, 32'd3, 32'd4);
    repeat (5) @(negedge Clk);
    #2 Rst = 1'b0;
    #1;
    chk("arst_busy", 64'(Busy), 64'h0);
    chk("arst_done", 64'(Done), 64'h0);
    chk("arst_hi",   64'(HiOut), 64'h0);
    chk("arst_lo",   64'(LoOut), 64'h0);
    chk("arst_dbz",  64'(DivByZero), 64'h0);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    chk("post_rst_busy", 64'(Busy), 64'h0);
    launch(2'd3, 32'd9, 32'd2);
    wait_done(n);
    chk("post_rst_lat", 64'(n), 64'd35);
    chk("post_rst_lo", 64'(LoOut), 64'd4);
    chk("post_rst_hi", 64'(HiOut), 64'd1);

    @(negedge Clk);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Iterative multiply/divide engine for the EX stage of the pipelined MIPS datapath. It sits between the ALU operand muxes and the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU operands, computes over WIDTH+3 cycles, and presents a registered 2×WIDTH result (HI:LO) with a one-cycle Done pulse. The pipeline controller stalls on Busy.

## Interface
- WIDTH, 32: operand width; HiOut/LoOut are each WIDTH bits.
- Clk  in  1  single clock; all state changes on rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Start  in  1  launch request; sampled only when Busy=0.
- Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; captured with Start.
- A  in  WIDTH  rs operand (multiplicand / dividend); captured with Start.
- B  in  WIDTH  rt operand (multiplier / divisor); captured with Start.
- Kill  in  1  pipeline flush; aborts the operation in flight.
- Busy  out  1  high in PREP, RUN, FIX.
- Done  out  1  one-cycle pulse in DONE; HiOut/LoOut are valid from this cycle on.
- HiOut  out  WIDTH  product high word / remainder.
- LoOut  out  WIDTH  product low word / quotient.
- DivByZero  out  1  registered; set with Done for a DIV/DIVU whose B=0; cleared on the next accepted Start.

## Operation
- States: IDLE, PREP, RUN, FIX, DONE. Reset state is IDLE.
- Reset values: Busy=0, Done=0, HiOut=0, LoOut=0, DivByZero=0, iteration counter=0.
- IDLE/DONE → PREP: on Start=1 (and Kill=0). Capture Op, A, B, and the sign flags.
  - Signed ops: record sA=A[WIDTH-1] and sB=B[WIDTH-1], then take magnitudes (two's-complement negate if negative).
  - Unsigned ops: sA=sB=0.
- DONE → IDLE: when Start=0.
- Start while Busy=1 is ignored. There is no queueing.
- PREP → RUN: load the counter with WIDTH.
  - Exception: for a divide with B=0, go PREP → DONE directly with HiOut=A (raw), LoOut=all ones, DivByZero=1.
- RUN: one iteration per cycle, counter decrements, RUN → FIX when counter reaches 1.
  - Multiply: radix-2 shift-add on a 2×WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle, remainder WIDTH+1 bits.
- FIX: sign correction.
  - Product is negated if sA^sB.
  - Quotient is negated if sA^sB; remainder is negated if sA (truncating division).
  - FIX → DONE, with HiOut/LoOut loaded on that edge.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF yields LoOut=0x80000000, HiOut=0, with no flag.
- Kill=1 in any state → IDLE on the next edge.
  - No Done is produced.
  - HiOut, LoOut and DivByZero keep their previous values.
  - Kill has priority over Start in the same cycle.
- HiOut/LoOut change only on entry to DONE (or reset). They hold between operations.

## Timing
- Start sampled at edge 0 → PREP during cycle 1 → RUN during cycles 2..WIDTH+1 → FIX during cycle WIDTH+2 → DONE (Done=1, results valid) during cycle WIDTH+3. This is 35 cycles at WIDTH=32.
- Divide-by-zero: Done during cycle 2.
- Busy rises in the cycle after the Start edge and falls in the DONE cycle.
- Back-to-back: Start asserted during DONE is accepted, and Done stays a single cycle.
- Rst low forces reset values immediately, without waiting for Clk, including mid-RUN.
- Outputs are registered; there is no combinational path from A/B/Op to the outputs.

## Test plan
- MULTU, A=B=0xFFFFFFFF, Start one cycle → Busy cycles 1–34, Done only in cycle 35, HiOut=0xFFFFFFFE, LoOut=0x00000001.
- MULT, A=−3 (0xFFFFFFFD), B=7 → HiOut=0xFFFFFFFF, LoOut=0xFFFFFFEB. Then DIV, A=−7, B=2, Start during the DONE cycle → LoOut=0xFFFFFFFD, HiOut=0xFFFFFFFF, 35 cycles later.
- DIVU, A=0x12345678, B=0 → Done in cycle 2, DivByZero=1, HiOut=0x12345678, LoOut=0xFFFFFFFF. The next Start clears DivByZero.
- DIV, A=0x80000000, B=0xFFFFFFFF → LoOut=0x80000000, HiOut=0, DivByZero=0. DIVU 100/7 → LoOut=14, HiOut=2.
- MULTU 5×6 started, Kill in cycle 10 → IDLE in cycle 11, no Done, HiOut/LoOut unchanged from the prior op. Start in cycle 11 is accepted normally. Start pulsed during RUN is ignored.
- Rst driven low mid-RUN (between clock edges) → Busy, Done, HiOut, LoOut and DivByZero all 0 immediately. After release, the state is IDLE.
